// File: rtl/portarb.sv
// ============================================================================
// Module   : portarb
// Purpose  : N-port request arbiter with registered one-hot grant, bounded
//            per-owner hold time and registered address/data forwarding.
//            Fixed priority by default; round-robin when PORTARB_RR_EN is
//            defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module portarb #(
  parameter int N = 3,    // number of requesting ports (2..8)
  parameter int A = 9,    // address width
  parameter int W = 128,  // data width
  parameter int H = 4     // max consecutive grant cycles per owner (1..16)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   csel_i,
  input  logic [N*A-1:0] addrIn_i,
  input  logic [N*W-1:0] dataIn_i,
  output logic [A-1:0]   addr_o,
  output logic [W-1:0]   data_o,
  output logic           valid_o,
  output logic [N-1:0]   grnt_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = (H > 1) ? $clog2(H) : 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [HW-1:0]   holdcnt_q, holdcnt_d;
  logic [N-1:0]    grnt_q, grnt_d;
  logic [A-1:0]    addr_q, addr_d;
  logic [W-1:0]    data_q, data_d;
`ifdef PORTARB_RR_EN
  logic [IW-1:0]   ptr_q, ptr_d;
`endif

  logic [N-1:0]    w_others;
  logic [N-1:0]    w_mask;
  logic [IW-1:0]   w_win;
  logic            w_found;
  logic            w_hold;
  logic [IW-1:0]   w_sel;

  // Winner search: the current owner steps aside whenever anyone else asks.
  always_comb begin
    w_others = csel_i & ~(N'(1) << owner_q);
    w_mask   = ((state_q == S_OWN) && (|w_others)) ? w_others : csel_i;
    w_win    = '0;
    w_found  = 1'b0;
`ifdef PORTARB_RR_EN
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= N) j = j - N;
      if (!w_found && w_mask[j]) begin
        w_win   = IW'(j);
        w_found = 1'b1;
      end
    end
`else
    for (int k = 0; k < N; k++) begin
      if (!w_found && w_mask[k]) begin
        w_win   = IW'(k);
        w_found = 1'b1;
      end
    end
`endif
  end

  // Next-state: idle on no request, extend the hold, or re-arbitrate.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    holdcnt_d = holdcnt_q;
    grnt_d    = grnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
`ifdef PORTARB_RR_EN
    ptr_d     = ptr_q;
`endif
    w_hold = (state_q == S_OWN) && csel_i[owner_q] && (holdcnt_q < HW'(H - 1));
    w_sel  = w_hold ? owner_q : w_win;

    if (csel_i == '0) begin
      state_d   = S_IDLE;
      grnt_d    = '0;
      holdcnt_d = '0;
    end else begin
      state_d = S_OWN;
      addr_d  = addrIn_i[w_sel*A +: A];
      data_d  = dataIn_i[w_sel*W +: W];
      if (w_hold) begin
        holdcnt_d = holdcnt_q + 1'b1;
      end else begin
        owner_d   = w_win;
        holdcnt_d = '0;
        grnt_d    = N'(1) << w_win;
`ifdef PORTARB_RR_EN
        ptr_d     = (w_win == IW'(N - 1)) ? '0 : w_win + 1'b1;
`endif
      end
    end
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= '0;
      holdcnt_q <= '0;
      grnt_q    <= '0;
      addr_q    <= '0;
      data_q    <= '0;
`ifdef PORTARB_RR_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      holdcnt_q <= holdcnt_d;
      grnt_q    <= grnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
`ifdef PORTARB_RR_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign grnt_o  = grnt_q;
  assign valid_o = |grnt_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule

`default_nettype wire

// File: tb/tb_portarb.sv
// ============================================================================
// Module   : tb_portarb
// Purpose  : Directed self-checking bench for portarb (H=4 and H=1 instances
//            sharing the same stimulus).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_portarb;

  localparam int N = 3;
  localparam int A = 9;
  localparam int W = 128;

  logic           clk;
  logic           rst;
  logic [N-1:0]   csel;
  logic [N*A-1:0] addr_in;
  logic [N*W-1:0] data_in;

  logic [A-1:0]   u0_addr, u1_addr;
  logic [W-1:0]   u0_data, u1_data;
  logic           u0_valid, u1_valid;
  logic [N-1:0]   u0_grnt, u1_grnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [A-1:0] pa [N];
  logic [W-1:0] pd [N];

  portarb #(.N(N), .A(A), .W(W), .H(4)) u0 (
    .clk(clk), .rst(rst), .csel_i(csel), .addrIn_i(addr_in), .dataIn_i(data_in),
    .addr_o(u0_addr), .data_o(u0_data), .valid_o(u0_valid), .grnt_o(u0_grnt)
  );

  portarb #(.N(N), .A(A), .W(W), .H(1)) u1 (
    .clk(clk), .rst(rst), .csel_i(csel), .addrIn_i(addr_in), .dataIn_i(data_in),
    .addr_o(u1_addr), .data_o(u1_data), .valid_o(u1_valid), .grnt_o(u1_grnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] exp_g;
    logic [N-1:0] seq_h1 [4];

    pa[0] = 9'h0A0; pa[1] = 9'h0B1; pa[2] = 9'h1C2;
    for (int i = 0; i < N; i++) pd[i] = {4{32'hDA7A_0000 + i}};
    addr_in = {pa[2], pa[1], pa[0]};
    data_in = {pd[2], pd[1], pd[0]};
`ifdef PORTARB_RR_EN
    seq_h1[0] = 3'b001; seq_h1[1] = 3'b010; seq_h1[2] = 3'b100; seq_h1[3] = 3'b001;
`else
    seq_h1[0] = 3'b001; seq_h1[1] = 3'b010; seq_h1[2] = 3'b001; seq_h1[3] = 3'b010;
`endif

    // Reset state
    rst  = 1'b1;
    csel = '0;
    #2;
    chk("rst_grnt",  W'(u0_grnt), W'(3'b000));
    chk("rst_valid", W'(u0_valid), W'(1'b0));
    chk("rst_addr",  W'(u0_addr), '0);
    chk("rst_data",  u0_data, '0);
    #10 rst = 1'b0;

    // Idle for three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_grnt",  W'(u0_grnt), W'(3'b000));
      chk("idle_valid", W'(u0_valid), W'(1'b0));
      chk("idle_addr",  W'(u0_addr), '0);
      chk("idle_data",  u0_data, '0);
    end

    // Sole requester: continuous grant, holdcnt wraps 0..3
    csel = 3'b001;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("sole_grnt",    W'(u0_grnt), W'(3'b001));
      chk("sole_valid",   W'(u0_valid), W'(1'b1));
      chk("sole_holdcnt", W'(u0.holdcnt_q), W'(i % 4));
      chk("sole_h1_grnt", W'(u1_grnt), W'(3'b001));
    end
    chk("sole_addr", W'(u0_addr), W'(pa[0]));

    // Idle holds last addr/data
    csel = 3'b000;
    tick();
    chk("idle2_grnt",  W'(u0_grnt), W'(3'b000));
    chk("idle2_valid", W'(u0_valid), W'(1'b0));
    chk("idle2_addr",  W'(u0_addr), W'(pa[0]));
    chk("idle2_data",  u0_data, pd[0]);

    // Two requesters alternate every 4 cycles
    csel = 3'b110;
    for (int i = 0; i < 10; i++) begin
      tick();
      exp_g = (((i / 4) % 2) == 0) ? 3'b010 : 3'b100;
      chk("alt_grnt",  W'(u0_grnt), W'(exp_g));
      chk("alt_valid", W'(u0_valid), W'(1'b1));
    end
    chk("alt_data", u0_data, pd[1]);

    // Port 1 at holdcnt 2, then only port 2 requests
    tick();
    chk("drop_pre_grnt", W'(u0_grnt), W'(3'b010));
    chk("drop_pre_hc",   W'(u0.holdcnt_q), W'(2));
    csel = 3'b100;
    tick();
    chk("drop_grnt", W'(u0_grnt), W'(3'b100));
    chk("drop_hc",   W'(u0.holdcnt_q), W'(0));
    chk("drop_data", u0_data, pd[2]);
    chk("drop_addr", W'(u0_addr), W'(pa[2]));

    // Asynchronous reset mid-burst
    tick();
    chk("burst_grnt", W'(u0_grnt), W'(3'b100));
    #3 rst = 1'b1;
    #1;
    chk("arst_grnt",  W'(u0_grnt), W'(3'b000));
    chk("arst_valid", W'(u0_valid), W'(1'b0));
    chk("arst_addr",  W'(u0_addr), '0);
    chk("arst_data",  u0_data, '0);
    @(posedge clk);
    #3;
    rst  = 1'b0;
    csel = 3'b010;
    tick();
    chk("post_rst_grnt", W'(u0_grnt), W'(3'b010));
    chk("post_rst_hc",   W'(u0.holdcnt_q), W'(0));
    chk("post_rst_addr", W'(u0_addr), W'(pa[1]));

    // H=1 with all ports requesting: re-arbitrate every cycle
    #2 rst = 1'b1;
    csel = 3'b111;
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("h1_grnt", W'(u1_grnt), W'(seq_h1[i]));
      chk("h1_valid", W'(u1_valid), W'(1'b1));
      case (seq_h1[i])
        3'b001:  chk("h1_addr", W'(u1_addr), W'(pa[0]));
        3'b010:  chk("h1_addr", W'(u1_addr), W'(pa[1]));
        default: chk("h1_addr", W'(u1_addr), W'(pa[2]));
      endcase
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
